// File: rtl/rv_pkg.sv
// Shared constants and types for the ID/EX operand stage: datapath widths,
// ALU control codes and the layout of the held ID/EX instruction record.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_CTRL_W = 5;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 5'b00001;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 5'b00010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 5'b00011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 5'b00100;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 5'b00101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 5'b00110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 5'b00111;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 5'b01000;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 5'b01001;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic                  sel_a_pc;
    logic                  sel_b_imm;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } idex_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding for one source register: EX/MEM beats MEM/WB beats the
// held register-file value. Loads in EX/MEM have no result yet, so they never forward.
module fwd_mux #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [XLEN-1:0]       held_data_i,
  input  logic [REG_ADDR_W-1:0] exmem_rd_i,
  input  logic                  exmem_reg_write_i,
  input  logic                  exmem_mem_read_i,
  input  logic [XLEN-1:0]       exmem_result_i,
  input  logic [REG_ADDR_W-1:0] memwb_rd_i,
  input  logic                  memwb_reg_write_i,
  input  logic [XLEN-1:0]       memwb_result_i,
  output logic [XLEN-1:0]       fwd_data_o
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_reg_write_i && !exmem_mem_read_i &&
                     (exmem_rd_i != '0) && (exmem_rd_i == rs_i);
  assign memwb_hit = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i);

  always_comb begin
    fwd_data_o = held_data_i;
    if (exmem_hit) begin
      fwd_data_o = exmem_result_i;
    end else if (memwb_hit) begin
      fwd_data_o = memwb_result_i;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register in front of the ALU: holds one decoded instruction behind a
// valid/ready handshake, forwards its operands and stalls decode on load-use.
module alu_operand_stage #(
  parameter int XLEN       = rv_pkg::XLEN,
  parameter int REG_ADDR_W = rv_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic                  in_use_rs1,
  input  logic                  in_use_rs2,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic                  in_sel_a_pc,
  input  logic                  in_sel_b_imm,
  input  logic [4:0]            in_alu_ctrl,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_reg_write,
  input  logic                  exmem_mem_read,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_reg_write,
  input  logic [XLEN-1:0]       memwb_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  output logic [4:0]            alu_ctrl,
  output logic [XLEN-1:0]       store_data,
  output logic [XLEN-1:0]       out_pc,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write
);

  import rv_pkg::*;

  logic  valid_q, valid_d;
  idex_t held_q, held_d;

  logic load_use;
  logic fire_in;
  logic fire_out;
  logic refresh_rs1;
  logic refresh_rs2;

  assign load_use = in_valid && valid_q && held_q.mem_read && (held_q.rd != '0) &&
                    ((in_use_rs1 && (in_rs1 == held_q.rd)) ||
                     (in_use_rs2 && (in_rs2 == held_q.rd)));

  assign in_ready = (!valid_q || out_ready) && !load_use && !flush;
  assign fire_in  = in_valid && in_ready;
  assign fire_out = valid_q && out_ready;

  // A stalled instruction can outlive its producer's MEM/WB slot; capture the value as it retires.
  assign refresh_rs1 = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == held_q.rs1);
  assign refresh_rs2 = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == held_q.rs2);

  always_comb begin
    valid_d = valid_q;
    held_d  = held_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (fire_in) begin
      valid_d          = 1'b1;
      held_d.pc        = in_pc;
      held_d.rs1       = in_rs1;
      held_d.rs2       = in_rs2;
      held_d.rs1_data  = in_rs1_data;
      held_d.rs2_data  = in_rs2_data;
      held_d.imm       = in_imm;
      held_d.sel_a_pc  = in_sel_a_pc;
      held_d.sel_b_imm = in_sel_b_imm;
      held_d.alu_ctrl  = in_alu_ctrl;
      held_d.rd        = in_rd;
      held_d.reg_write = in_reg_write;
      held_d.mem_read  = in_mem_read;
      held_d.mem_write = in_mem_write;
    end else if (fire_out) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      if (refresh_rs1) held_d.rs1_data = memwb_result;
      if (refresh_rs2) held_d.rs2_data = memwb_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      held_q  <= '0;
    end else begin
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  logic [1:0][REG_ADDR_W-1:0] src_idx;
  logic [1:0][XLEN-1:0]       src_data;
  logic [1:0][XLEN-1:0]       fwd_data;

  assign src_idx[0]  = held_q.rs1;
  assign src_idx[1]  = held_q.rs2;
  assign src_data[0] = held_q.rs1_data;
  assign src_data[1] = held_q.rs2_data;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    fwd_mux #(
      .XLEN       (XLEN),
      .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_mux (
      .rs_i              (src_idx[gi]),
      .held_data_i       (src_data[gi]),
      .exmem_rd_i        (exmem_rd),
      .exmem_reg_write_i (exmem_reg_write),
      .exmem_mem_read_i  (exmem_mem_read),
      .exmem_result_i    (exmem_result),
      .memwb_rd_i        (memwb_rd),
      .memwb_reg_write_i (memwb_reg_write),
      .memwb_result_i    (memwb_result),
      .fwd_data_o        (fwd_data[gi])
    );
  end

  assign out_valid     = valid_q;
  assign alu_a         = held_q.sel_a_pc  ? held_q.pc  : fwd_data[0];
  assign alu_b         = held_q.sel_b_imm ? held_q.imm : fwd_data[1];
  assign store_data    = fwd_data[1];
  assign alu_ctrl      = held_q.alu_ctrl;
  assign out_pc        = held_q.pc;
  assign out_rd        = held_q.rd;
  assign out_reg_write = held_q.reg_write;
  assign out_mem_read  = held_q.mem_read;
  assign out_mem_write = held_q.mem_write;

endmodule
